// File: rtl/cpu_defs.sv
// Shared CPU definitions: multiplier width, latency and sequencer state encoding.
package cpu_defs;
  localparam int MUL_WIDTH   = 32;
  localparam int MUL_LATENCY = 37;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREP_A = 3'd1,
    ST_PREP_B = 3'd2,
    ST_ITER   = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5,
    ST_DONE   = 3'd6
  } mul_state_t;
endpackage

// File: rtl/adder_32bits.sv
// Plain 32-bit adder, shared by every arithmetic step of the multiply sequencer.
module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  assign s = a + b;
endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32->64 shift-add multiplier for MULT/MULTU with one shared adder.
// Handshake: start is accepted in IDLE/DONE when flush=0; done pulses one cycle with hi/lo valid.
module mul_seq_ctrl
  import cpu_defs::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       dbg_state
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  mul_state_t       r_state, w_next;
  logic [WIDTH-1:0] r_mcand, r_mq, r_acc, r_lo_fix, r_hi, r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_signed, r_neg, r_z;
  logic [WIDTH-1:0] w_add_a, w_add_b, w_sum;
  logic             w_carry, w_accept;

  adder_32bits u_adder (
    .a (w_add_a),
    .b (w_add_b),
    .s (w_sum)
  );

  assign w_accept  = (r_state == ST_IDLE || r_state == ST_DONE) && start && !flush;
  assign w_carry   = (w_sum < r_acc);
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

  // Adder operand muxing and next-state selection.
  always_comb begin
    w_add_a = r_acc;
    w_add_b = '0;
    w_next  = r_state;
    case (r_state)
      ST_IDLE:   w_next = w_accept ? ST_PREP_A : ST_IDLE;
      ST_DONE:   w_next = w_accept ? ST_PREP_A : ST_IDLE;
      ST_PREP_A: begin
        w_add_a = ~r_mcand;
        w_add_b = ONE;
        w_next  = ST_PREP_B;
      end
      ST_PREP_B: begin
        w_add_a = ~r_mq;
        w_add_b = ONE;
        w_next  = ST_ITER;
      end
      ST_ITER: begin
        w_add_a = r_acc;
        w_add_b = r_mq[0] ? r_mcand : '0;
        if (r_cnt == CNT_W'(WIDTH - 1)) w_next = ST_FIX_LO;
      end
      ST_FIX_LO: begin
        w_add_a = ~r_mq;
        w_add_b = ONE;
        w_next  = ST_FIX_HI;
      end
      ST_FIX_HI: begin
        // Borrow from the low word propagates only when the low magnitude was zero.
        w_add_a = ~r_acc;
        w_add_b = {{(WIDTH-1){1'b0}}, r_z};
        w_next  = ST_DONE;
      end
      default:   w_next = ST_IDLE;
    endcase
    if (busy && flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mq     <= '0;
      r_acc    <= '0;
      r_lo_fix <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_mcand  <= a;
            r_mq     <= b;
            r_signed <= is_signed;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        ST_PREP_A: if (r_signed && r_mcand[WIDTH-1]) r_mcand <= w_sum;
        ST_PREP_B: begin
          if (r_signed && r_mq[WIDTH-1]) r_mq <= w_sum;
          r_acc <= '0;
          r_cnt <= '0;
        end
        ST_ITER: begin
          r_acc <= {w_carry, w_sum[WIDTH-1:1]};
          r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX_LO: begin
          r_lo_fix <= r_neg ? w_sum : r_mq;
          r_z      <= (r_mq == '0);
        end
        ST_FIX_HI: begin
          if (!flush) begin
            r_hi <= r_neg ? w_sum : r_acc;
            r_lo <= r_lo_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Multi-cycle 32x32 -> 64-bit multiply sequencer for the pipelined CPU's EX stage, serving MULT and MULTU. It time-shares one adder_32bits instance across every operation: operand absolute value, shift-add iterations and result negation. The EX stage stalls on busy and writes HI/LO on done.

Parameters:
WIDTH, 32, operand width; only 32 supported (matches adder_32bits)
CNT_W, 6, iteration counter width (holds 0..WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with start
a  input  32  multiplicand, captured with start
b  input  32  multiplier, captured with start
flush  input  1  pipeline flush; aborts the operation in flight
busy  output  1  operation in progress (PREP_A..FIX_HI)
done  output  1  one-cycle pulse; hi/lo valid
hi  output  32  product[63:32]
lo  output  32  product[31:0]

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst.
- On reset: state=IDLE; busy=0, done=0, hi=0, lo=0; internal registers cleared.
- States: IDLE, PREP_A, PREP_B, ITER, FIX_LO, FIX_HI, DONE.
- IDLE or DONE with start=1 and flush=0: capture a, b and is_signed. Record neg = is_signed & (a[31]^b[31]). Go to PREP_A.
- PREP_A: if is_signed & a[31], mcand = ~a + 1 (adder a=~a, b=1); else mcand = a. Go to PREP_B.
- PREP_B: the same operation on b into the mq register. Clear acc and cnt. Go to ITER.
- ITER: one iteration per cycle, WIDTH cycles in total.
  - sum = acc + (mq[0] ? mcand : 0) through the adder.
  - carry = (sum < acc), compared unsigned.
  - {acc, mq} <= {carry, sum, mq} >> 1.
  - cnt++. When cnt reaches WIDTH-1, go to FIX_LO.
- FIX_LO: if neg, lo_r = ~mq + 1 (adder) and borrow flag z = (mq == 0); else lo_r = mq. Go to FIX_HI.
- FIX_HI: if neg, hi_r = ~acc + z (adder); else hi_r = acc. Go to DONE.
  - FIX states always take 2 cycles, so latency does not depend on the data.
- DONE: done=1 for one cycle; hi/lo drive the final values. Next state is IDLE, or PREP_A if start is accepted.
- Latency: start sampled at edge T gives busy=1 for T+1..T+36 and done=1 in cycle T+37. Fixed at 37 cycles for every operand.
- hi/lo update only on entering DONE. They hold until the next DONE or reset and are never visible mid-operation.
- start while busy: ignored, no queuing.
- flush:
  - Any busy state: go to IDLE at the next edge. No done pulse; hi/lo unchanged.
  - Same cycle as start in IDLE/DONE: flush wins and start is ignored.
  - flush=1 in the DONE cycle: the done pulse still completes and hi/lo are kept.
- Signed edge case: 0x80000000 magnitude stays 0x80000000 (unsigned interpretation). The result is correct with no overflow.
- Adder usage: exactly one adder_32bits instance, with muxed inputs per state. No other '+' on 32-bit data. The 6-bit cnt increment is exempt.
- rst asserted mid-operation: immediate return to reset state and values; no done.

Decomposition:
- Shared package (cpu_defs): MUL_WIDTH=32, MUL_LATENCY=37, and the state encoding localparams (3-bit: IDLE=0, PREP_A=1, PREP_B=2, ITER=3, FIX_LO=4, FIX_HI=5, DONE=6).
- Sub-module: the existing adder_32bits, instantiated once inside mul_seq_ctrl. No new sub-module; FSM and datapath muxing stay in one file.

Test Plan:
- MULTU a=6, b=7, start at T -> busy T+1..T+36; done only at T+37; hi=0x00000000, lo=0x0000002A.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- After 6x7 completes, start MULTU 3x3 and assert flush at T+10 -> busy=0 at T+11; no done; hi/lo stay 0/0x2A. Restart -> lo=9 after 37 cycles.
- Start while busy with different operands -> ignored; the original result appears. Start held high in the DONE cycle -> second op accepted; next done 37 cycles later.
- rst pulsed at T+20 mid-op -> busy/done/hi/lo=0 immediately, before the next clock edge; FSM in IDLE.
